// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: reads one instruction word per PC, hands it to decode, and
// steers the ProgramCounter by +4 or to a redirect target.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  instr_fetch_if.master     bus
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_instr;

  logic              w_redirect;
  logic              w_accept;
  logic              w_capture;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_redirect = redirect_valid && (r_state != IDLE);
  assign w_pc_inc   = pc + ADDR_W'(INSTR_BYTES);

  assign bus.imem_addr = {pc[ADDR_W-1:2], 2'b00};
  assign bus.if_valid  = (r_state == HOLD);
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_req_pc remembers the unaligned PC of the accepted request so if_pc
  // reports it verbatim once the response lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_pc   <= '0;
      r_if_pc    <= '0;
      r_if_instr <= DATA_W'(NOP_INSTR);
    end else begin
      if (w_accept) begin
        r_req_pc <= pc;
      end
      if (w_capture) begin
        r_if_instr <= bus.imem_rdata;
        r_if_pc    <= r_req_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.imem_req = 1'b0;
    pc_enable    = 1'b0;
    pc_next      = w_pc_inc;
    w_accept     = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = w_redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (w_redirect) begin
            w_state_nxt = REQ;
          end else begin
            w_capture   = 1'b1;
            pc_enable   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (w_redirect) begin
          w_state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (w_redirect || bus.id_ready) begin
          w_state_nxt = REQ;
        end
      end
      // A response arriving here belongs to a request made before a redirect.
      DRAIN: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_redirect) begin
      pc_enable = 1'b1;
      pc_next   = redirect_target;
    end
  end

endmodule
